// File: rtl/bootstrap_loader_if.sv
// Pin bundle for bootstrap_loader: micro boot-control lines, flash SPI pins and async SRAM pins.
// master = loader side, slave = board/micro side.
interface bootstrap_loader_if #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] micro_addr;
   logic              boot_init;
   logic [DATA_W-1:0] magic_word;
   logic [8:0]        image_len;
   logic              write_en;
   logic              micro_req;
   logic [2:0]        flags;
   logic              init_done;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_data;
   logic              sram_cs_n;
   logic              sram_we_n;
   logic              sram_oe_n;
   logic              sram_adv_n;
   logic [1:0]        sram_lb_ub_n;
   logic              sram_wait;
   logic              error;
   logic              miso;
   logic              mosi;
   logic              ss_n;
   logic              sck;

   modport master (
      input  micro_addr, boot_init, magic_word, image_len, write_en, micro_req, miso,
      output flags, init_done, sram_addr, sram_data, sram_cs_n, sram_we_n, sram_oe_n,
             sram_adv_n, sram_lb_ub_n, sram_wait, error, mosi, ss_n, sck
   );

   modport slave (
      output micro_addr, boot_init, magic_word, image_len, write_en, micro_req, miso,
      input  flags, init_done, sram_addr, sram_data, sram_cs_n, sram_we_n, sram_oe_n,
             sram_adv_n, sram_lb_ub_n, sram_wait, error, mosi, ss_n, sck
   );
endinterface

// File: rtl/bootstrap_loader.sv
// Boot loader: copies a SPI-flash image (magic word first) into async SRAM, then grants the micro SRAM reads.
// Latency: 2*SCK_DIV clocks per SPI bit plus a 6-clock SRAM write per word; BOOTSTRAP_CHECKSUM_EN adds a checked trailing word.
// Backpressure: write_en low parks the loader in WRITE with SCK held low and SS still asserted.
module bootstrap_loader #(
   parameter int          ADDR_W     = 23,
   parameter int          DATA_W     = 16,
   parameter int          SCK_DIV    = 4,
   parameter logic [23:0] FLASH_BASE = 24'h0
) (
   input logic                clk,
   input logic                rst_n,
   bootstrap_loader_if.master bus
);
`ifdef BOOTSTRAP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, CMD, MAGIC, READ, WRITE, CHECK, DONE, ERROR} state_t;
`else
   typedef enum logic [2:0] {IDLE, CMD, MAGIC, READ, WRITE, DONE, ERROR} state_t;
`endif

   localparam int DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int MAX_BITS = (DATA_W > 32) ? DATA_W : 32;
   localparam int BIT_W    = $clog2(MAX_BITS + 1);
   localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(31);
   localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(DATA_W - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);

   state_t            state_q, state_d;
   logic              init_q;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              sck_q;
   logic              ss_q;
   logic [31:0]       cmd_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] magic_q;
   logic [8:0]        len_q;
   logic [ADDR_W-1:0] wr_addr;
   logic [2:0]        wcyc;
`ifdef BOOTSTRAP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q;
`endif

   logic start, shifting, busy, tick, rise, fall, last_bit, last_word, wr_done;
   logic in_wr, wr_strobe, micro_rd;

   always_comb begin
      shifting = 1'b0;
      case (state_q)
         CMD, MAGIC, READ: shifting = 1'b1;
`ifdef BOOTSTRAP_CHECKSUM_EN
         CHECK:            shifting = 1'b1;
`endif
         default:          shifting = 1'b0;
      endcase
   end

   assign busy      = shifting || (state_q == WRITE);
   assign start     = bus.boot_init && !init_q &&
                      (state_q == IDLE || state_q == DONE || state_q == ERROR);
   assign tick      = (div_cnt == DIV_LAST);
   assign rise      = shifting && tick && !sck_q;
   assign fall      = shifting && tick && sck_q;
   // A bit is complete on the falling SCK edge that follows its sample point.
   assign last_bit  = fall && (bit_cnt == ((state_q == CMD) ? CMD_LAST : WORD_LAST));
   assign last_word = (wr_addr == ADDR_W'(len_q));
   assign wr_done   = (state_q == WRITE) && (wcyc == 3'd5);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start) state_d = CMD;
         CMD:   if (last_bit) state_d = MAGIC;
         MAGIC: if (last_bit) state_d = (rx_sr == magic_q) ? READ : ERROR;
         READ:  if (last_bit) state_d = WRITE;
         WRITE: begin
            if (wr_done) begin
               if (!last_word) begin
                  state_d = READ;
               end else begin
`ifdef BOOTSTRAP_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = DONE;
`endif
               end
            end
         end
`ifdef BOOTSTRAP_CHECKSUM_EN
         CHECK: if (last_bit) state_d = (rx_sr == sum_q) ? DONE : ERROR;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         init_q  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         sck_q   <= 1'b0;
         ss_q    <= 1'b1;
         cmd_sr  <= '0;
         rx_sr   <= '0;
         word_q  <= '0;
         magic_q <= '0;
         len_q   <= '0;
         wr_addr <= '0;
         wcyc    <= '0;
`ifdef BOOTSTRAP_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         init_q  <= bus.boot_init;
         ss_q    <= (state_d == IDLE) || (state_d == DONE) || (state_d == ERROR);
         if (start) begin
            len_q   <= bus.image_len;
            magic_q <= bus.magic_word;
            cmd_sr  <= {8'h03, FLASH_BASE};
            div_cnt <= '0;
            bit_cnt <= '0;
            sck_q   <= 1'b0;
            wr_addr <= '0;
            wcyc    <= '0;
`ifdef BOOTSTRAP_CHECKSUM_EN
            sum_q   <= '0;
`endif
         end else if (shifting) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) sck_q <= !sck_q;
            if (rise) rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
            if (fall) begin
               bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
               if (state_q == CMD) cmd_sr <= {cmd_sr[30:0], 1'b0};
            end
            if (last_bit && state_q == READ) begin
               word_q <= rx_sr;
`ifdef BOOTSTRAP_CHECKSUM_EN
               sum_q  <= sum_q + rx_sr;
`endif
            end
         end else if (state_q == WRITE) begin
            // wcyc 0 = waiting for write permit, 1..5 = SRAM cycle c0..c4
            if (wcyc == 3'd0) begin
               if (bus.write_en) wcyc <= 3'd1;
            end else if (wcyc == 3'd5) begin
               wcyc    <= 3'd0;
               wr_addr <= wr_addr + 1'b1;
            end else begin
               wcyc <= wcyc + 3'd1;
            end
         end
      end
   end

   assign in_wr     = (state_q == WRITE);
   assign wr_strobe = in_wr && (wcyc >= 3'd1) && (wcyc <= 3'd4);
   assign micro_rd  = (state_q == DONE) && bus.micro_req;

   assign bus.sram_addr    = micro_rd ? bus.micro_addr : (in_wr ? wr_addr : '0);
   assign bus.sram_data    = in_wr ? word_q : '0;
   assign bus.sram_cs_n    = !(micro_rd || wr_strobe);
   assign bus.sram_we_n    = !(in_wr && (wcyc >= 3'd2) && (wcyc <= 3'd4));
   assign bus.sram_oe_n    = !micro_rd;
   assign bus.sram_adv_n   = !(micro_rd || (in_wr && wcyc == 3'd1));
   assign bus.sram_lb_ub_n = (micro_rd || wr_strobe) ? 2'b00 : 2'b11;
   assign bus.sram_wait    = busy;
   assign bus.flags        = {state_q == ERROR, state_q == DONE, busy};
   assign bus.init_done    = (state_q == DONE);
   assign bus.error        = (state_q == ERROR);
   assign bus.mosi         = cmd_sr[31];
   assign bus.ss_n         = ss_q;
   assign bus.sck          = sck_q;
endmodule

// File: tb/tb_bootstrap_loader.sv
// Bench for bootstrap_loader: SPI flash model, SRAM-write and boot-status scoreboards, directed scenarios.
module tb_bootstrap_loader;
   localparam int ADDR_W = 23;
   localparam int DATA_W = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   bootstrap_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   bootstrap_loader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCK_DIV(1), .FLASH_BASE(24'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   wr_t        exp_wr[$];
   logic [4:0] exp_st[$];

   // Flash model: captures 32 command/address bits, then streams flash_mem MSB first
   logic [15:0] flash_mem [0:7];
   int          rise_cnt = 0;
   logic [31:0] cmd_cap  = '0;

   always @(posedge bus.sck or posedge bus.ss_n) begin
      if (bus.ss_n) begin
         rise_cnt = 0;
      end else begin
         if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], bus.mosi};
         rise_cnt++;
      end
   end

   always @(negedge bus.sck or posedge bus.ss_n) begin
      int k;
      if (bus.ss_n) begin
         bus.miso = 1'b0;
      end else if (rise_cnt >= 32) begin
         k = rise_cnt - 32;
         bus.miso = (k / 16 < 8) ? flash_mem[k / 16][15 - (k % 16)] : 1'b0;
      end
   end

   // Monitor: pops expected SRAM writes on each we falling edge, boot status on busy falling edge
   logic we_prev   = 1'b1;
   logic busy_prev = 1'b0;
   always @(negedge clk) begin
      wr_t        e;
      logic [4:0] s, got_s;
      if (rst_n) begin
         if (we_prev && !bus.sram_we_n) begin
            n_vec++;
            if (exp_wr.size() == 0) begin
               n_err++;
               $display("FAIL sram_write: unexpected write addr=%0h data=%0h, none required",
                        bus.sram_addr, bus.sram_data);
            end else begin
               e = exp_wr.pop_front();
               if ({bus.sram_addr, bus.sram_data} !== e) begin
                  n_err++;
                  $display("FAIL sram_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                           bus.sram_addr, bus.sram_data, e.addr, e.data);
               end
            end
         end
         if (busy_prev && !bus.flags[0]) begin
            n_vec++;
            got_s = {bus.flags, bus.init_done, bus.error};
            if (exp_st.size() == 0) begin
               n_err++;
               $display("FAIL boot_status: unexpected end of boot, status=%b", got_s);
            end else begin
               s = exp_st.pop_front();
               if (got_s !== s) begin
                  n_err++;
                  $display("FAIL boot_status: got {flags,done,err}=%b, required %b", got_s, s);
               end
            end
         end
      end
      we_prev   = bus.sram_we_n;
      busy_prev = bus.flags[0];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string name);
      check({name, "_pins"},
            {bus.flags, bus.init_done, bus.error, bus.sram_cs_n, bus.sram_we_n, bus.sram_oe_n,
             bus.sram_adv_n, bus.sram_lb_ub_n, bus.sram_wait, bus.mosi, bus.ss_n, bus.sck},
            {3'b000, 1'b0, 1'b0, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0});
      check({name, "_addr_data"}, {bus.sram_addr, bus.sram_data}, '0);
   endtask

   task automatic start_boot();
      bus.boot_init = 1'b1;
      tick(2);
      bus.boot_init = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (bus.flags[0] && t < 4000) begin
         tick(1);
         t++;
      end
      check({name, "_in_time"}, (t < 4000), 1);
      tick(2);
   endtask

   task automatic push_image();
      for (int i = 0; i < 4; i++)
         exp_wr.push_back({ADDR_W'(i), 16'(16'h1111 * (i + 1))});
   endtask

   initial begin
      int t;
      int sck_hi, we_lo;
      bus.boot_init  = 1'b0;
      bus.micro_addr = '0;
      bus.magic_word = 16'hB007;
      bus.image_len  = 9'd3;
      bus.write_en   = 1'b1;
      bus.micro_req  = 1'b0;
      flash_mem[0] = 16'hB007; flash_mem[1] = 16'h1111; flash_mem[2] = 16'h2222;
      flash_mem[3] = 16'h3333; flash_mem[4] = 16'h4444; flash_mem[5] = 16'hAAAA;
      flash_mem[6] = 16'h0000; flash_mem[7] = 16'h0000;

      #1 rst_n = 1'b0;
      #20;
      check_reset("reset");
      rst_n = 1'b1;
      tick(2);

      // micro read request before boot must be ignored
      bus.micro_req  = 1'b1;
      bus.micro_addr = 23'h2;
      tick(1);
      check("preboot_oe_cs", {bus.sram_oe_n, bus.sram_cs_n}, 2'b11);
      check("preboot_addr", bus.sram_addr, 0);
      bus.micro_req = 1'b0;

      // normal boot with a write-permit stall at word 2
      push_image();
      exp_st.push_back(5'b010_1_0);
      start_boot();
      check("boot_busy", {bus.flags, bus.sram_wait, bus.ss_n}, {3'b001, 1'b1, 1'b0});
      bus.micro_req = 1'b1;
      tick(3);
      check("busy_micro_oe", bus.sram_oe_n, 1);
      bus.micro_req = 1'b0;
      t = 0;
      while (exp_wr.size() > 2 && t < 2000) begin
         tick(1);
         t++;
      end
      check("reach_word1", exp_wr.size(), 2);
      bus.write_en = 1'b0;
      tick(40);
      sck_hi = 0;
      we_lo  = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.sck) sck_hi++;
         if (!bus.sram_we_n) we_lo++;
         tick(1);
      end
      check("stall_sck_high", sck_hi, 0);
      check("stall_we_low", we_lo, 0);
      check("stall_state", {bus.flags, bus.ss_n, exp_wr.size()}, {3'b001, 1'b0, 32'd2});
      bus.write_en = 1'b1;
      wait_idle("boot1");
      check("flash_cmd", cmd_cap, 32'h0300_0000);
      check("boot1_writes_left", exp_wr.size(), 0);
      check("done_pins", {bus.sram_wait, bus.ss_n, bus.init_done}, 3'b011);

      // micro read after DONE
      bus.micro_req  = 1'b1;
      bus.micro_addr = 23'h2;
      tick(1);
      check("micro_addr", bus.sram_addr, 23'h2);
      check("micro_strobes",
            {bus.sram_cs_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_adv_n, bus.sram_lb_ub_n},
            {1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
      bus.micro_req = 1'b0;
      tick(1);
      check("micro_release", {bus.sram_cs_n, bus.sram_oe_n}, 2'b11);

      // wrong magic word
      flash_mem[0] = 16'hDEAD;
      exp_st.push_back(5'b100_0_1);
      start_boot();
      wait_idle("magic_err");
      check("magic_err_flags", {bus.flags, bus.error, bus.init_done}, {3'b100, 1'b1, 1'b0});
      bus.micro_req = 1'b1;
      tick(1);
      check("err_micro_denied", {bus.sram_cs_n, bus.sram_oe_n, bus.ss_n}, 3'b111);
      bus.micro_req = 1'b0;
      flash_mem[0] = 16'hB007;

      // reset while reading word 1
      exp_wr.push_back({ADDR_W'(0), 16'h1111});
      start_boot();
      t = 0;
      while (exp_wr.size() > 0 && t < 2000) begin
         tick(1);
         t++;
      end
      check("reach_word0", exp_wr.size(), 0);
      tick(10);
      rst_n = 1'b0;
      #2;
      check_reset("midread_reset");
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check("post_reset_idle", {bus.flags, bus.ss_n}, 4'b000_1);
      push_image();
      exp_st.push_back(5'b010_1_0);
      start_boot();
      wait_idle("reboot");
      check("reboot_writes_left", exp_wr.size(), 0);

`ifdef BOOTSTRAP_CHECKSUM_EN
      // bad trailing checksum word
      flash_mem[5] = 16'h0000;
      push_image();
      exp_st.push_back(5'b100_0_1);
      start_boot();
      wait_idle("cksum_err");
      check("cksum_err_flags", {bus.flags, bus.error}, 4'b100_1);
      flash_mem[5] = 16'hAAAA;
`endif

      check("queues_empty", exp_wr.size() + exp_st.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
